// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing, lock-state encoding and the saturating
// counter helper shared by the VGA sync receiver.
package vga_timing_pkg;

  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 525;
  localparam int H_ACT_START_DEF = 143;
  localparam int H_ACT_LEN_DEF   = 640;
  localparam int V_ACT_START_DEF = 34;
  localparam int V_ACT_LEN_DEF   = 480;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    LS_SEARCH = 2'd0,
    LS_VERIFY = 2'd1,
    LS_LOCKED = 2'd2
  } lock_state_t;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Strobe-gated sync register with falling-edge detect; fall compares the
// previous strobe's sample against the current input.
module vga_edge_det (
  input  logic clock,
  input  logic reset_n,
  input  logic sample_en,
  input  logic d,
  output logic fall
);

  logic q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= 1'b1;
    end else if (sample_en) begin
      q <= d;
    end
  end

  assign fall = sample_en & q & ~d;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: measures line/frame lengths from the sampled syncs,
// locks onto the nominal timing and emits active-area pixel coordinates.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_LEN   = H_ACT_LEN_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_LEN   = V_ACT_LEN_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sample_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  disp_RGB,
  // pix_valid qualifies pix_x/pix_y/pix_rgb for the strobe that produced
  // them; there is no ready, the consumer takes the pixel or loses it.
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic [7:0]  err_count,
  output lock_state_t lock_state
);

  localparam logic [9:0]  H_TOT = 10'(H_TOTAL);
  localparam logic [9:0]  V_TOT = 10'(V_TOTAL);
  localparam logic [9:0]  H_AS  = 10'(H_ACT_START);
  localparam logic [9:0]  V_AS  = 10'(V_ACT_START);
  localparam logic [10:0] H_END = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [10:0] V_END = 11'(V_ACT_START + V_ACT_LEN);

  logic       h_fall, v_fall;
  logic [9:0] hcnt, vcnt, hcnt_n, vcnt_n;
  logic [9:0] line_done, frame_done;
  logic [1:0] state, state_n;
  logic       line_err, line_err_n;
  logic [7:0] err_n;
  logic       line_bad, frame_bad, h_ovf, act;

  vga_edge_det u_hs (
    .clock     (clock),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .d         (hsync),
    .fall      (h_fall)
  );

  vga_edge_det u_vs (
    .clock     (clock),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .d         (vsync),
    .fall      (v_fall)
  );

  assign line_done  = sat_inc(hcnt);
  assign frame_done = sat_inc(vcnt);
  assign line_bad   = h_fall && (line_done != H_TOT);
  // A frame is only measurable when vsync falls on a line boundary.
  assign frame_bad  = v_fall && !(h_fall && (frame_done == V_TOT));
  assign locked     = (state == ST_LOCKED);
  assign lock_state = lock_state_t'(state);

  always_comb begin
    hcnt_n     = h_fall ? 10'd0 : sat_inc(hcnt);
    vcnt_n     = vcnt;
    if (h_fall) vcnt_n = v_fall ? 10'd0 : frame_done;
    h_ovf      = (hcnt_n == CNT_MAX);
    state_n    = state;
    line_err_n = line_err;
    err_n      = err_count;
    case (state)
      ST_SEARCH: begin
        if (v_fall) begin
          state_n    = ST_VERIFY;
          line_err_n = 1'b0;
        end
      end
      ST_VERIFY: begin
        if (line_bad) line_err_n = 1'b1;
        if (v_fall) begin
          if (!line_err && !line_bad && !frame_bad) state_n = ST_LOCKED;
          line_err_n = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (line_bad || frame_bad || h_ovf) begin
          state_n = ST_SEARCH;
          err_n   = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
        end
      end
      default: state_n = ST_SEARCH;
    endcase
    act = (state_n == ST_LOCKED) &&
          (hcnt_n >= H_AS) && ({1'b0, hcnt_n} < H_END) &&
          (vcnt_n >= V_AS) && ({1'b0, vcnt_n} < V_END);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hcnt        <= CNT_MAX;
      vcnt        <= CNT_MAX;
      state       <= ST_SEARCH;
      line_err    <= 1'b0;
      line_len    <= 10'd0;
      frame_lines <= 10'd0;
      err_count   <= 8'd0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 3'd0;
    end else begin
      frame_start <= v_fall;
      if (sample_en) begin
        hcnt      <= hcnt_n;
        vcnt      <= vcnt_n;
        state     <= state_n;
        line_err  <= line_err_n;
        err_count <= err_n;
        if (h_fall) line_len <= line_done;
        if (h_fall && v_fall) frame_lines <= frame_done;
        pix_valid <= act;
        pix_x     <= hcnt_n - H_AS;
        pix_y     <= vcnt_n - V_AS;
        pix_rgb   <= act ? disp_RGB : 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a shrunken 20x8 raster with a
// pixel scoreboard fed by the driver and drained by an output monitor.
module tb_vga_sync_receiver;
  import vga_timing_pkg::*;

  localparam int HT  = 20;
  localparam int VT  = 8;
  localparam int HAS = 5;
  localparam int HAL = 10;
  localparam int VAS = 2;
  localparam int VAL = 4;
  localparam int BIG = 100000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        sample_en;
  logic        hsync;
  logic        vsync;
  logic [2:0]  disp_RGB;
  logic [9:0]  pix_x, pix_y;
  logic [2:0]  pix_rgb;
  logic        pix_valid;
  logic        frame_start;
  logic        locked;
  logic [9:0]  line_len, frame_lines;
  logic [7:0]  err_count;
  lock_state_t lock_state;

  logic [22:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_seen = 0;
  int fs_count = 0;
  int exp_frames = 0;
  logic strobe_seen = 1'b0;

  vga_sync_receiver #(
    .H_TOTAL     (HT),
    .V_TOTAL     (VT),
    .H_ACT_START (HAS),
    .H_ACT_LEN   (HAL),
    .V_ACT_START (VAS),
    .V_ACT_LEN   (VAL)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .disp_RGB    (disp_RGB),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .err_count   (err_count),
    .lock_state  (lock_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: one pixel compare per strobe that presents pix_valid
  always @(posedge clock) strobe_seen <= sample_en & reset_n;

  always @(negedge clock) begin
    logic [22:0] e;
    if (frame_start) fs_count++;
    if (strobe_seen && pix_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%0d, expected no pixel",
                 pix_x, pix_y, pix_rgb);
      end else begin
        e = exp_q.pop_front();
        n_seen++;
        if ({pix_x, pix_y, pix_rgb} !== e) begin
          n_fail++;
          $display("FAIL pix_data: got x=%0d y=%0d rgb=%0d, expected x=%0d y=%0d rgb=%0d",
                   pix_x, pix_y, pix_rgb, e[22:13], e[12:3], e[2:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_rgb"}, pix_rgb, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_state"}, int'(lock_state), int'(LS_SEARCH));
  endtask

  // Entered at a negedge; strobed syncs must be ignored while in reset.
  task automatic pulse_reset(input string tag);
    reset_n = 1'b0; sample_en = 1'b1; hsync = 1'b0; vsync = 1'b0;
    @(negedge clock);
    reset_n = 1'b1; sample_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    check_idle(tag);
  endtask

  task automatic drive_sample(input logic hs, input logic vs, input logic [2:0] rgb);
    hsync = hs; vsync = vs; disp_RGB = rgb; sample_en = 1'b1;
    @(negedge clock);
    sample_en = 1'b0;
    @(negedge clock);
  endtask

  // Samples s < lock_samples are expected to be seen while locked.
  task automatic send_line(input int l, input int len, input int lock_samples, input int rst_at);
    if (l == 0) exp_frames++;
    for (int s = 0; s < len; s++) begin
      logic [2:0] rgb;
      if (s == rst_at) pulse_reset("midreset");
      rgb = 3'((s + 2 * l) % 8);
      if (s == HAS && l == VAS) rgb = 3'd5;
      if (s < lock_samples && s >= HAS && s < HAS + HAL && l >= VAS && l < VAS + VAL) begin
        exp_q.push_back({10'(s - HAS), 10'(l - VAS), rgb});
        n_push++;
      end
      drive_sample(s < 3 ? 1'b0 : 1'b1, l < 2 ? 1'b0 : 1'b1, rgb);
      if (s == HAS && l == VAS && s < lock_samples) begin
        check("first_pix_valid", pix_valid, 1);
        check("first_pix_x", pix_x, 0);
        check("first_pix_y", pix_y, 0);
        check("first_pix_rgb", pix_rgb, 5);
      end
    end
  endtask

  task automatic send_lines(input int from, input int to, input int lock_samples);
    for (int l = from; l <= to; l++) send_line(l, HT, lock_samples, -1);
  endtask

  // stimulus
  initial begin
    reset_n = 1'b0; sample_en = 1'b0; hsync = 1'b1; vsync = 1'b1; disp_RGB = 3'd0;
    @(negedge clock);
    pulse_reset("reset");

    // A: first vsync fall, SEARCH -> VERIFY; lengths measured from saturated counters
    send_line(0, HT, 0, -1);
    check("a_state", int'(lock_state), int'(LS_VERIFY));
    check("a_line_len_sat", line_len, 1023);
    check("a_frame_lines_sat", frame_lines, 1023);
    check("a_fs_count", fs_count, 1);
    send_lines(1, VT - 1, 0);
    check("a_line_len", line_len, HT);
    check("a_locked", locked, 0);

    // B: second vsync fall locks
    send_line(0, HT, BIG, -1);
    check("b_locked", locked, 1);
    check("b_frame_lines", frame_lines, VT);
    check("b_err_count", err_count, 0);
    check("b_fs_count", fs_count, 2);
    send_lines(1, VT - 1, BIG);

    // C: nominal locked frame
    send_lines(0, VT - 1, BIG);
    check("c_locked", locked, 1);

    // D: one line of HT+1 samples breaks lock at the following hsync fall
    send_lines(0, 2, BIG);
    send_line(3, HT + 1, BIG, -1);
    send_line(4, HT, 0, -1);
    check("d_locked", locked, 0);
    check("d_err_count", err_count, 1);
    check("d_line_len", line_len, HT + 1);
    check("d_state", int'(lock_state), int'(LS_SEARCH));
    send_lines(5, VT - 1, 0);

    // E: VERIFY frame, F: relocked
    send_lines(0, VT - 1, 0);
    check("e_state", int'(lock_state), int'(LS_VERIFY));
    send_lines(0, VT - 1, BIG);
    check("f_locked", locked, 1);
    check("f_err_count", err_count, 1);

    // G: hsync held high 1100 samples; hcnt hits 1023 and drops lock once
    send_lines(0, 2, BIG);
    send_line(3, 1100, 1023, -1);
    check("g_err_count", err_count, 2);
    check("g_locked", locked, 0);
    check("g_state", int'(lock_state), int'(LS_SEARCH));
    send_line(4, HT, 0, -1);
    check("g_line_len_sat", line_len, 1023);
    send_lines(5, VT - 1, 0);

    // H: short frame (VT-1 lines) in VERIFY; I stays VERIFY; J locks
    send_lines(0, VT - 2, 0);
    send_line(0, HT, 0, -1);
    check("i_state", int'(lock_state), int'(LS_VERIFY));
    check("i_frame_lines", frame_lines, VT - 1);
    send_lines(1, VT - 1, 0);
    send_line(0, HT, BIG, -1);
    check("j_locked", locked, 1);
    check("j_frame_lines", frame_lines, VT);
    send_lines(1, VT - 1, BIG);

    // K: one-clock reset mid-line while locked; L verifies, M relocks
    send_lines(0, 2, BIG);
    send_line(3, HT, 9, 9);
    send_lines(4, VT - 1, 0);
    check("k_state", int'(lock_state), int'(LS_SEARCH));
    send_lines(0, VT - 1, 0);
    check("l_state", int'(lock_state), int'(LS_VERIFY));
    send_line(0, HT, BIG, -1);
    check("m_locked", locked, 1);
    check("m_err_count", err_count, 0);
    check("m_frame_lines", frame_lines, VT);
    send_lines(1, VT - 1, BIG);

    // final report
    repeat (2) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    check("pix_count", n_seen, n_push);
    check("frame_start_count", fs_count, exp_frames);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel samples per line.
REQ-002 Parameter V_TOTAL, default 525, lines per frame.
REQ-003 Parameter H_ACT_START, default 143, first active sample index after hsync fall; H_ACT_LEN, default 640.
REQ-004 Parameter V_ACT_START, default 34, first active line index after vsync fall; V_ACT_LEN, default 480.
REQ-005 clock  input  1  system clock; the block's only clock.
REQ-006 reset_n  input  1  reset; synchronous, active-low.
REQ-007 sample_en  input  1  pixel strobe; inputs are sampled only on clock edges where it is 1.
REQ-008 hsync / vsync  input  1 each  active-low sync pulses from the VGA source.
REQ-009 disp_RGB  input  3  pixel colour.
REQ-010 pix_x / pix_y  output  10 each  active-area coordinates of the current output pixel.
REQ-011 pix_rgb  output  3  captured colour; pix_valid  output  1  pixel is in active area and locked.
REQ-012 frame_start  output  1  one-clock pulse on each sampled vsync fall.
REQ-013 locked  output  1; line_len  output  10; frame_lines  output  10; err_count  output  8.

Function
REQ-014 The block SHALL act only on sample_en clocks; all outputs SHALL hold between strobes, except frame_start, which SHALL be 0.
REQ-015 The block SHALL register hsync/vsync each strobe; a fall SHALL be previous sample 1, current sample 0.
REQ-016 On an hsync fall, hcnt SHALL load 0; otherwise hcnt SHALL increment, saturating at 1023.
REQ-017 On an hsync fall, line_len SHALL latch hcnt+1 (length of the completed line), saturating at 1023.
REQ-018 On an hsync fall coinciding with a vsync fall, vcnt SHALL load 0 and frame_lines SHALL latch vcnt+1.
REQ-019 On an hsync fall without a vsync fall, vcnt SHALL increment, saturating at 1023.
REQ-020 A vsync fall without a coincident hsync fall SHALL still pulse frame_start; it SHALL NOT reset vcnt.
REQ-021 Lock FSM states: SEARCH, VERIFY, LOCKED; the reset state SHALL be SEARCH.
REQ-022 SEARCH SHALL go to VERIFY on a vsync fall and clear the line-error flag.
REQ-023 In VERIFY, any hsync fall with completed length != H_TOTAL SHALL set the line-error flag.
REQ-024 In VERIFY, the next vsync fall SHALL go to LOCKED if the flag is clear and the completed frame = V_TOTAL lines; otherwise the FSM SHALL stay in VERIFY with the flag cleared.
REQ-025 In LOCKED, a line length != H_TOTAL, a frame length != V_TOTAL, or hcnt reaching 1023 SHALL go to SEARCH and increment err_count, saturating at 255.
REQ-026 locked SHALL be 1 only in LOCKED.
REQ-027 pix_valid SHALL be 1 when locked, H_ACT_START <= hcnt < H_ACT_START+H_ACT_LEN, and V_ACT_START <= vcnt < V_ACT_START+V_ACT_LEN.
REQ-028 pix_x SHALL equal hcnt-H_ACT_START and pix_y SHALL equal vcnt-V_ACT_START, each 10-bit modulo.
REQ-029 pix_rgb SHALL equal disp_RGB when pix_valid is 1, else 0.
REQ-030 Latency: pix_* SHALL be registered and SHALL appear one clock after the sample_en edge that sampled the inputs.
REQ-031 Counters SHALL use 10-bit unsigned arithmetic; comparisons SHALL be unsigned.

Reset
REQ-032 With reset_n=0 at a clock edge: hcnt=vcnt=1023, FSM=SEARCH, all outputs 0, sync registers 1; sample_en SHALL be ignored.
REQ-033 Reset mid-frame SHALL discard all measurements; lock SHALL require a fresh SEARCH->VERIFY->LOCKED sequence.

Structure
REQ-034 Package vga_timing_pkg SHALL hold the 800/525/143/640/34/480 constants and the lock-state enumeration.
REQ-035 One sub-module, vga_edge_det (sample-gated register plus fall detector), SHALL be instantiated once for hsync and once for vsync.

Verification
REQ-036 Reset, then a nominal 640x480 source with sample_en every 2nd clock -> locked=1 after the 2nd vsync fall; err_count=0.
REQ-037 Locked, hold the first active pixel with disp_RGB=3'h5 -> pix_valid=1, pix_x=0, pix_y=0, pix_rgb=5 one clock later.
REQ-038 Locked, one line 801 samples long -> locked=0 at that hsync fall, err_count=1, line_len=801.
REQ-039 Locked, hsync held high for 1100 samples -> SEARCH at hcnt=1023, err_count increments once.
REQ-040 Frame of 524 lines while in VERIFY -> stays VERIFY; the next nominal frame -> LOCKED.
REQ-041 reset_n=0 for one clock mid-frame while locked -> all outputs 0 next clock; relock after two frames.
